// File: rtl/sign_ext_11b_unit_if.sv
`default_nettype none
// ============================================================================
// sign_ext_11b_unit_if : request/result bundle for the immediate extender
// Rev 1.0
// ============================================================================
interface sign_ext_11b_unit_if #(
  parameter int OUT_W = 16
);
  logic [10:0]      in;
  logic [1:0]       mode;
  logic             in_valid;
  logic [OUT_W-1:0] out;
  logic [OUT_W-1:0] out_q;
  logic             out_valid;
  logic             err;
  logic [15:0]      count;

  modport master (
    output in, mode, in_valid,
    input  out, out_q, out_valid, err, count
  );

  modport slave (
    input  in, mode, in_valid,
    output out, out_q, out_valid, err, count
  );
endinterface
`default_nettype wire

// File: rtl/sign_ext_11b_unit.sv
`default_nettype none
// ============================================================================
// sign_ext_11b_unit : selectable 11/8/5-bit sign or zero extender with a
//                     registered copy, range-error flag and acceptance counter
// Rev 1.0
// ============================================================================
module sign_ext_11b_unit #(
  parameter int OUT_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sign_ext_11b_unit_if.slave bus
);

  logic [10:0]      w_keep;
  logic             w_fill;
  logic             w_unused_nz;
  logic [OUT_W-1:0] w_out;

  logic [OUT_W-1:0] r_out_q;
  logic             r_valid;
  logic             r_err;
  logic [15:0]      r_count;

  // w_keep marks the low input bits passed through; w_fill feeds every other bit
  always_comb begin
    w_keep      = 11'h7FF;
    w_fill      = bus.in[10];
    w_unused_nz = 1'b0;
    case (bus.mode)
      2'b01: begin
        w_keep      = 11'h0FF;
        w_fill      = bus.in[7];
        w_unused_nz = |bus.in[10:8];
      end
      2'b10: begin
        w_keep      = 11'h01F;
        w_fill      = bus.in[4];
        w_unused_nz = |bus.in[10:5];
      end
      2'b11: begin
        w_fill      = 1'b0;
      end
      default: ;
    endcase
  end

  // Per-bit select keeps X/Z on any input bit visible at the output
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    if (i < 11) begin : g_low
      assign w_out[i] = w_keep[i] ? bus.in[i] : w_fill;
    end else begin : g_high
      assign w_out[i] = w_fill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_count <= 16'h0000;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out_q <= w_out;
        r_err   <= w_unused_nz;
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign bus.out       = w_out;
  assign bus.out_q     = r_out_q;
  assign bus.out_valid = r_valid;
  assign bus.err       = r_err;
  assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sign_ext_11b_unit.sv
`default_nettype none
// ============================================================================
// tb_sign_ext_11b_unit : directed + random checks against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_sign_ext_11b_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_q;
  logic        exp_err;
  logic        exp_valid;
  logic [15:0] exp_cnt;

  sign_ext_11b_unit_if #(.OUT_W(16)) bus ();

  sign_ext_11b_unit #(.OUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Value of the selected field read as a two's-complement (or unsigned) integer
  function automatic logic [15:0] ref_ext(input logic [10:0] i, input logic [1:0] m);
    int v;
    case (m)
      2'd0:    begin v = int'(i);        if (v >= 1024) v -= 2048; end
      2'd1:    begin v = int'(i) % 256;  if (v >= 128)  v -= 256;  end
      2'd2:    begin v = int'(i) % 32;   if (v >= 16)   v -= 32;   end
      default: v = int'(i);
    endcase
    return v[15:0];
  endfunction

  function automatic logic ref_err(input logic [10:0] i, input logic [1:0] m);
    if (m == 2'd1) return (int'(i) >= 256);
    if (m == 2'd2) return (int'(i) >= 32);
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_out_q"},     bus.out_q,               exp_q);
    chk({tag, "_out_valid"}, {15'd0, bus.out_valid},  {15'd0, exp_valid});
    chk({tag, "_err"},       {15'd0, bus.err},        {15'd0, exp_err});
    chk({tag, "_count"},     bus.count,               exp_cnt);
  endtask

  // One cycle: drive at negedge, check comb path, then registered state after posedge
  task automatic step(input logic [10:0] i, input logic [1:0] m, input logic v, input string tag);
    @(negedge clk);
    bus.in = i; bus.mode = m; bus.in_valid = v;
    #1;
    chk({tag, "_out"}, bus.out, ref_ext(i, m));
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) begin
      exp_q   = ref_ext(i, m);
      exp_err = ref_err(i, m);
      exp_cnt = exp_cnt + 16'd1;
    end
    chk_regs(tag);
  endtask

  initial begin
    logic [15:0] exp_x;
    logic [10:0] r_in;
    logic [1:0]  r_mode;
    logic        r_v;

    rst = 1'b1;
    bus.in = 11'h000; bus.mode = 2'b00; bus.in_valid = 1'b0;
    exp_q = 16'h0; exp_err = 1'b0; exp_valid = 1'b0; exp_cnt = 16'h0;
    #1;
    chk_regs("reset");

    // Combinational path checked with no clock edge yet, while still in reset
    bus.in = 11'b01111111111; #1; chk("comb_max_pos", bus.out, 16'h03FF);
    bus.in = 11'b10000000000; #1; chk("comb_max_neg", bus.out, 16'hFC00);

    @(negedge clk);
    rst = 1'b0;

    step(11'h0FF, 2'b01, 1'b1, "m01_ff");
    chk("m01_ff_lit", bus.out_q, 16'hFFFF);
    step(11'h1FF, 2'b01, 1'b1, "m01_1ff");
    chk("m01_1ff_err_lit", {15'd0, bus.err}, 16'h0001);

    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in = 11'h010; bus.mode = 2'b10; #1; chk("comb_m10", bus.out, 16'hFFF0);
    bus.in = 11'h7FF; bus.mode = 2'b11; #1; chk("comb_m11", bus.out, 16'h07FF);
    @(posedge clk); #1;
    exp_valid = 1'b0;
    chk_regs("idle0");

    for (int n = 0; n < 120; n++) begin
      r_in = 11'($urandom);
      step(r_in, 2'b00, 1'b1, "rand_m00");
    end

    for (int n = 0; n < 200; n++) begin
      r_in   = 11'($urandom);
      r_mode = 2'($urandom);
      r_v    = ($urandom_range(0, 3) != 0);
      step(r_in, r_mode, r_v, "rand_mix");
    end

    step(11'h120, 2'b10, 1'b1, "err_m10");
    for (int n = 0; n < 3; n++) step(11'h7FF, 2'b01, 1'b0, "idle_hold");

    // Asynchronous reset between edges, with in_valid held high
    step(11'h3AB, 2'b00, 1'b1, "pre_rst");
    @(negedge clk);
    #2;
    bus.in = 11'h155; bus.mode = 2'b00; bus.in_valid = 1'b1;
    rst = 1'b1;
    #1;
    exp_q = 16'h0; exp_err = 1'b0; exp_valid = 1'b0; exp_cnt = 16'h0;
    chk_regs("async_rst");
    chk("rst_comb_out", bus.out, 16'h0155);
    @(posedge clk); #1;
    chk_regs("rst_held_valid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q = 16'h0155; exp_valid = 1'b1; exp_cnt = 16'h1;
    chk_regs("post_rst_first");

    // Counter wrap from a clean reset
    @(negedge clk);
    rst = 1'b1; #1; rst = 1'b0;
    bus.in = 11'h0FF; bus.mode = 2'b11; bus.in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    exp_q = 16'h00FF; exp_err = 1'b0; exp_valid = 1'b1; exp_cnt = 16'hFFFF;
    chk_regs("cnt_ffff");
    @(posedge clk); #1;
    exp_cnt = 16'h0000;
    chk_regs("cnt_wrap");
    step(11'h001, 2'b00, 1'b0, "wrap_idle");

    // Unknown bits must reach the output per bit
    @(negedge clk);
    bus.in = 11'bx0000000000; bus.mode = 2'b00; bus.in_valid = 1'b0;
    #1;
    exp_x = 16'bxxxxxx0000000000;
    chk("x_prop", bus.out, exp_x);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
